// File: rtl/aurora_hls_nfc.sv
// Aurora 64B/66B native flow control generator.
// Issues XOFF on RX FIFO full and XON once it drains.
module aurora_hls_nfc #(
  parameter logic [15:0] XOFF_CODE = 16'hFFFF,
  parameter logic [15:0] XON_CODE  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rx_prog_full,
  input  logic        fifo_rx_prog_empty,
  input  logic        s_axi_nfc_tready,
  output logic        s_axi_nfc_tvalid,
  output logic [15:0] s_axi_nfc_tdata,
  input  logic        rx_tvalid,
  output logic [31:0] full_trigger_count,
  output logic [31:0] empty_trigger_count
);

  typedef enum logic [1:0] {
    RUN,
    SEND_XOFF,
    PAUSED,
    SEND_XON
  } state_t;

  state_t      state_q, state_d;
  logic        full_q, empty_q;
  logic        tvalid_q, tvalid_d;
  logic [15:0] tdata_q, tdata_d;
  logic [31:0] full_cnt_q, full_cnt_d;
  logic [31:0] empty_cnt_q, empty_cnt_d;

  // rx_tvalid is reserved and intentionally has no effect.
  logic unused_rx;
  assign unused_rx = rx_tvalid;

  // Register FIFO flags; all decisions use these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      full_q  <= fifo_rx_prog_full;
      empty_q <= fifo_rx_prog_empty;
    end
  end

  // State, request and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      tvalid_q    <= 1'b0;
      tdata_q     <= 16'h0000;
      full_cnt_q  <= 32'd0;
      empty_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      full_cnt_q  <= full_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  // Next-state: one request per pause/resume cycle, held until accepted.
  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    full_cnt_d  = full_cnt_q;
    empty_cnt_d = empty_cnt_q;
    unique case (state_q)
      RUN: begin
        if (full_q) begin
          state_d    = SEND_XOFF;
          tvalid_d   = 1'b1;
          tdata_d    = XOFF_CODE;
          full_cnt_d = full_cnt_q + 32'd1;
        end
      end
      SEND_XOFF: begin
        if (s_axi_nfc_tready) begin
          state_d  = PAUSED;
          tvalid_d = 1'b0;
        end
      end
      PAUSED: begin
        if (empty_q && !full_q) begin
          state_d     = SEND_XON;
          tvalid_d    = 1'b1;
          tdata_d     = XON_CODE;
          empty_cnt_d = empty_cnt_q + 32'd1;
        end
      end
      SEND_XON: begin
        if (s_axi_nfc_tready) begin
          state_d  = RUN;
          tvalid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign s_axi_nfc_tvalid    = tvalid_q;
  assign s_axi_nfc_tdata     = tdata_q;
  assign full_trigger_count  = full_cnt_q;
  assign empty_trigger_count = empty_cnt_q;

endmodule

// File: tb/tb_aurora_hls_nfc.sv
// Bench for aurora_hls_nfc: directed table,
// hand-written corner sequences and random vs. model.
module tb_aurora_hls_nfc;

  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic        empty;
  logic        tready;
  logic        rx;
  logic        tvalid;
  logic [15:0] tdata;
  logic [31:0] fcnt;
  logic [31:0] ecnt;

  int checks = 0;
  int errors = 0;

  aurora_hls_nfc dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_rx_prog_full   (full),
    .fifo_rx_prog_empty  (empty),
    .s_axi_nfc_tready    (tready),
    .s_axi_nfc_tvalid    (tvalid),
    .s_axi_nfc_tdata     (tdata),
    .rx_tvalid           (rx),
    .full_trigger_count  (fcnt),
    .empty_trigger_count (ecnt)
  );

  always #5 clk = ~clk;

  // Reference: link is either flowing or paused; at most one
  // request can be outstanding; flags are seen one edge late.
  bit          m_seen_full, m_seen_empty;
  bit          m_pending, m_paused;
  logic [15:0] m_code;
  logic [31:0] m_fc, m_ec;

  task automatic model_edge();
    if (rst) begin
      m_seen_full  = 0;
      m_seen_empty = 0;
      m_pending    = 0;
      m_paused     = 0;
      m_code       = 16'h0000;
      m_fc         = 0;
      m_ec         = 0;
    end else begin
      if (m_pending) begin
        if (tready) m_pending = 0;
      end else if (!m_paused && m_seen_full) begin
        m_pending = 1;
        m_paused  = 1;
        m_code    = 16'hFFFF;
        m_fc      = m_fc + 1;
      end else if (m_paused && m_seen_empty && !m_seen_full) begin
        m_pending = 1;
        m_paused  = 0;
        m_code    = 16'h0000;
        m_ec      = m_ec + 1;
      end
      m_seen_full  = full;
      m_seen_empty = empty;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          r, f, e, t;
    bit          v;
    logic [15:0] d;
    logic [31:0] fc, ec;
  } vec_t;

  vec_t tbl[21];
  int   n;

  initial begin
    rx     = 1'bx;
    rst    = 1;
    full   = 0;
    empty  = 0;
    tready = 0;

    //         r  f  e  t   v  d         fc ec
    tbl[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 16'h0000, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 16'h0000, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 16'h0000, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 1, 16'hFFFF, 1, 0};
    tbl[6]  = '{0, 1, 1, 0, 1, 16'hFFFF, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 1, 16'hFFFF, 1, 0};
    tbl[8]  = '{0, 0, 1, 1, 0, 16'hFFFF, 1, 0};
    tbl[9]  = '{0, 0, 1, 1, 1, 16'h0000, 1, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 16'h0000, 1, 1};
    tbl[11] = '{0, 0, 1, 1, 0, 16'h0000, 1, 1};
    tbl[12] = '{0, 1, 0, 1, 0, 16'h0000, 1, 1};
    tbl[13] = '{0, 1, 0, 1, 1, 16'hFFFF, 2, 1};
    tbl[14] = '{0, 1, 0, 1, 0, 16'hFFFF, 2, 1};
    tbl[15] = '{0, 1, 1, 1, 0, 16'hFFFF, 2, 1};
    tbl[16] = '{0, 1, 1, 1, 0, 16'hFFFF, 2, 1};
    tbl[17] = '{0, 0, 1, 1, 0, 16'hFFFF, 2, 1};
    tbl[18] = '{0, 0, 1, 0, 1, 16'h0000, 2, 2};
    tbl[19] = '{0, 1, 0, 0, 1, 16'h0000, 2, 2};
    tbl[20] = '{1, 1, 0, 0, 0, 16'h0000, 0, 0};

    #2;
    foreach (tbl[i]) begin
      rst    = tbl[i].r;
      full   = tbl[i].f;
      empty  = tbl[i].e;
      tready = tbl[i].t;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(tvalid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_data", i), 32'(tdata), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_fcnt", i), fcnt, tbl[i].fc);
      chk($sformatf("tbl%0d_ecnt", i), ecnt, tbl[i].ec);
    end

    // XOFF latency and hold with tready low.
    rst = 1; full = 0; empty = 0; tready = 0;
    step(); step();
    rst = 0;
    repeat (4) step();
    full = 1;
    n = 0;
    while (!tvalid && n < 10) begin
      step();
      n++;
    end
    chk("xoff_latency", n, 2);
    repeat (5) begin
      step();
      chk("xoff_hold_valid", 32'(tvalid), 1);
      chk("xoff_hold_data", 32'(tdata), 32'hFFFF);
    end
    chk("xoff_fcnt", fcnt, 1);
    chk("xoff_ecnt", ecnt, 0);

    // Accept: one cycle later tvalid drops, no repeat request.
    tready = 1;
    step();
    chk("xoff_drop", 32'(tvalid), 0);
    repeat (20) begin
      step();
      chk("paused_quiet", 32'(tvalid), 0);
    end
    chk("paused_fcnt", fcnt, 1);

    // XON two edges after empty rises, single-cycle pulse.
    full = 0;
    repeat (5) step();
    empty = 1;
    step();
    chk("xon_edge1", 32'(tvalid), 0);
    step();
    chk("xon_edge2_valid", 32'(tvalid), 1);
    chk("xon_edge2_data", 32'(tdata), 32'h0000);
    step();
    chk("xon_pulse_end", 32'(tvalid), 0);
    chk("xon_ecnt", ecnt, 1);
    chk("xon_fcnt", fcnt, 1);

    // Reset aborts a pending XOFF.
    empty = 0; tready = 0; full = 1;
    repeat (3) step();
    chk("pre_abort_valid", 32'(tvalid), 1);
    rst = 1;
    step();
    chk("abort_valid", 32'(tvalid), 0);
    chk("abort_data", 32'(tdata), 32'h0000);
    chk("abort_fcnt", fcnt, 0);
    rst = 0; full = 0; tready = 1;
    repeat (4) begin
      step();
      chk("after_abort", 32'(tvalid), 0);
    end

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      full   = ($urandom_range(0, 3) == 0);
      empty  = ($urandom_range(0, 2) == 0);
      tready = ($urandom_range(0, 1) == 1);
      step();
      chk("rnd_valid", 32'(tvalid), 32'(m_pending));
      chk("rnd_data", 32'(tdata), 32'(m_code));
      chk("rnd_fcnt", fcnt, m_fc);
      chk("rnd_ecnt", ecnt, m_ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_hls_nfc.md
Name: aurora_hls_nfc

Overview:
- Native flow control (NFC) generator for an Aurora 64B/66B link.
- Watches the programmable-full and programmable-empty flags of the local RX FIFO.
- Issues an XOFF request to the Aurora core's NFC AXI-Stream port when the FIFO fills, and an XON request once it drains.
- Provides 32-bit counters of issued XOFF and XON requests for host-visible status.

Parameters:
- XOFF_CODE, 16'hFFFF, NFC payload sent to pause the remote transmitter.
- XON_CODE, 16'h0000, NFC payload sent to resume the remote transmitter.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_rx_prog_full  input  1  RX FIFO programmable-full flag, level.
- fifo_rx_prog_empty  input  1  RX FIFO programmable-empty flag, level.
- s_axi_nfc_tready  input  1  Aurora NFC port ready.
- s_axi_nfc_tvalid  output  1  NFC request valid.
- s_axi_nfc_tdata  output  16  NFC request payload (XOFF_CODE or XON_CODE).
- rx_tvalid  input  1  RX data valid; reserved, no effect on any output, tolerates X/undriven.
- full_trigger_count  output  32  number of XOFF requests issued.
- empty_trigger_count  output  32  number of XON requests issued.

Behaviour:
- Input registration: full_q and empty_q sample fifo_rx_prog_full and fifo_rx_prog_empty every cycle. All decisions use only the registered copies.

Reset (rst=1 at a clock edge):
- s_axi_nfc_tvalid=0, s_axi_nfc_tdata=16'h0000.
- Both counters 0; full_q=empty_q=0; state RUN.
- Reset asserted mid-handshake aborts the pending request without completing it.

FSM states:
- RUN: link flowing, no request outstanding.
- SEND_XOFF: XOFF outstanding.
- PAUSED: XOFF accepted.
- SEND_XON: XON outstanding.

Transitions (evaluated each edge):
- RUN and full_q=1 -> SEND_XOFF. At the same edge: tvalid<=1, tdata<=XOFF_CODE, full_trigger_count<=count+1.
- SEND_XOFF: hold tvalid=1 and tdata stable while tready=0. When tvalid&tready at an edge -> PAUSED, tvalid<=0.
- PAUSED and empty_q=1 and full_q=0 -> SEND_XON. At the same edge: tvalid<=1, tdata<=XON_CODE, empty_trigger_count<=count+1.
- SEND_XON: hold until tvalid&tready at an edge -> RUN, tvalid<=0.
- Latency: a flag rising between edges k-1 and k is registered at edge k; tvalid is high after edge k+1, i.e. 2 cycles.
- With tready already high, tvalid stays high for exactly one cycle.
- tdata retains the last issued code after the handshake; it changes only when a new request starts or on reset.

Boundary conditions:
- Level-triggered but state-guarded: a flag held high issues exactly one request per pause/resume cycle.
- full_q=1 while PAUSED: no action.
- empty_q=1 while RUN (including after reset): no XON.
- Both flags high in RUN: XOFF wins. Both high in PAUSED: stay PAUSED until full_q drops.
- Flag changes during SEND_XOFF or SEND_XON are ignored until the handshake completes. The payload never changes while tvalid=1 and tready=0.
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0. Each counter increments exactly once per request, at request start, independent of tready.
- tvalid never deasserts without a handshake except on reset.

Test Plan:
1. Hold rst=1 for 2 cycles, full=empty=tready=0 -> tvalid=0, tdata=0x0000, both counters 0.
2. Release reset, wait 4 cycles, raise full with tready=0 and wait 5 cycles -> tvalid=1 and tdata=0xFFFF, held stable; full_trigger_count=1, empty_trigger_count=0.
3. Raise tready=1 and hold 20 cycles -> tvalid drops one cycle after tready rises; no further requests; full_trigger_count stays 1.
4. Drop full, wait 5 cycles, raise empty -> tvalid=1 with tdata=0x0000 exactly 2 edges after empty rises, one-cycle pulse; empty_trigger_count=1, full_trigger_count=1.
5. Raise empty while in RUN after reset -> no request issued, counters unchanged. Raise full and empty together -> XOFF only.
6. Assert rst while an XOFF is pending with tready=0 -> tvalid=0, tdata=0x0000, counters 0, FSM returns to RUN. Drive rx_tvalid to X throughout -> outputs unaffected.
